fetch_queue: RTL and testbench

Instruction buffer between the fetch stage (PC register plus instruction memory read) and decode. It accepts {PC+4, instruction} pairs from fetch with a valid/ready handshake and holds up to DEPTH of them in FIFO order. It presents the oldest pair to decode, so the two stages are decoupled and decode stalls do not require freezing the PC register. A synchronous flush discards every buffered entry on a taken branch or jump.

---
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of {pc, instr} pairs.
// Optional same-cycle pass-through when empty is enabled by defining FETCHQ_BYPASS_EN.

package fetch_queue_pkg;

    localparam int unsigned WORD_W = 32;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fq_entry_t;

endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_pc,
    input  logic [WORD_W-1:0]        in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        out_pc,
    output logic [WORD_W-1:0]        out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fq_entry_t         mem [DEPTH];
    fq_entry_t         head;
    fq_entry_t         in_entry;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              empty;
    logic              full;
    logic              bypass;
    logic              push;
    logic              pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign head     = mem[rd_ptr];
    assign in_entry = '{pc: in_pc, instr: in_instr};

    // A pair offered to an empty queue may be presented to decode in the same cycle.
`ifdef FETCHQ_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // Handshake decode and output selection; outputs read zero when nothing is valid.
    always_comb begin
        in_ready  = ~full;
        out_valid = ~empty | bypass;
        out_pc    = '0;
        out_instr = '0;
        if (!empty) begin
            out_pc    = head.pc;
            out_instr = head.instr;
        end else if (bypass) begin
            out_pc    = in_entry.pc;
            out_instr = in_entry.instr;
        end
        // A bypassed pair taken by decode is never written into storage.
        push = in_valid & ~full & ~(bypass & out_ready);
        pop  = ~empty & out_ready;
    end

    assign count = cnt;

    // Pointer and occupancy update; flush outranks push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default and FETCHQ_BYPASS_EN builds).

module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_pc     = '0;
    logic [31:0] in_instr  = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    logic [31:0] t_pc  [4];
    logic [31:0] t_ins [4];

    initial begin
        t_pc[0] = 32'd4;  t_ins[0] = 32'h2008_0001;
        t_pc[1] = 32'd8;  t_ins[1] = 32'h2009_0002;
        t_pc[2] = 32'd12; t_ins[2] = 32'h8C0A_0000;
        t_pc[3] = 32'd16; t_ins[3] = 32'hAC0B_0004;

        // Reset release with nothing offered
        #12 reset = 1'b1;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_pc",    out_pc,         32'd0);
        check("rst_out_instr", out_instr,      32'd0);

        // Fill to DEPTH with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t_pc[i], t_ins[i]);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        drive(1'b0, 32'd0, 32'd0);
        check("full_in_ready",  32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc",    out_pc,    t_pc[i]);
            check("drain_instr", out_instr, t_ins[i]);
            step();
        end
        check("empty_out_valid", 32'(out_valid), 32'd0);
        check("empty_count",     32'(count),     32'd0);
        check("empty_out_pc",    out_pc,         32'd0);

        // Prime to two entries, then stream push+pop for 10 cycles across the wrap
        out_ready = 1'b0;
        drive(1'b1, 32'd20, ins_of(32'd20));
        step();
        drive(1'b1, 32'd24, ins_of(32'd24));
        step();
        check("prime_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(28 + 4 * k), ins_of(32'(28 + 4 * k)));
            check("stream_pc",    out_pc,         32'(20 + 4 * k));
            check("stream_instr", out_instr,      ins_of(32'(20 + 4 * k)));
            check("stream_count", 32'(count),     32'd2);
            step();
        end
        check("stream_end_count", 32'(count), 32'd2);
        check("stream_end_pc",    out_pc,     32'd60);

        // Fill, then offer a pair on the same edge as a pop while full
        out_ready = 1'b0;
        drive(1'b1, 32'd68, ins_of(32'd68));
        step();
        drive(1'b1, 32'd72, ins_of(32'd72));
        step();
        check("full2_count",    32'(count),    32'd4);
        check("full2_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        step();
        drive(1'b0, 32'd0, 32'd0);
        check("fullpop_count",    32'(count),    32'd3);
        check("fullpop_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("fullpop_pc", out_pc, 32'(64 + 4 * k));
            step();
        end
        check("fullpop_drained", 32'(out_valid), 32'd0);

        // Flush with three held and a pair offered in the same cycle
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(100 + 4 * k), ins_of(32'(100 + 4 * k)));
            step();
        end
        check("preflush_count", 32'(count), 32'd3);
        flush = 1'b1;
        drive(1'b1, 32'd36, 32'h0800_0010);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        check("flush_count",     32'(count),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready",  32'(in_ready),  32'd1);
        drive(1'b1, 32'd40, 32'h0000_1234);
        step();
        check("postflush_pc",    out_pc,     32'd40);
        check("postflush_instr", out_instr,  32'h0000_1234);
        check("postflush_count", 32'(count), 32'd1);

        // Asynchronous reset between edges while two are held
        drive(1'b1, 32'd48, ins_of(32'd48));
        step();
        drive(1'b0, 32'd0, 32'd0);
        check("prereset_count", 32'(count), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_count",     32'(count),     32'd0);
        check("async_out_pc",    out_pc,         32'd0);
        check("async_in_ready",  32'(in_ready),  32'd1);
        #2 reset = 1'b1;
        step();
        check("after_reset_count", 32'(count), 32'd0);

        // Empty queue, pair offered with decode ready
        out_ready = 1'b1;
        drive(1'b1, 32'd44, ins_of(32'd44));
        #1;
`ifdef FETCHQ_BYPASS_EN
        check("bypass_out_valid", 32'(out_valid), 32'd1);
        check("bypass_out_pc",    out_pc,         32'd44);
        step();
        drive(1'b0, 32'd0, 32'd0);
        check("bypass_count", 32'(count), 32'd0);
`else
        check("nobypass_out_valid", 32'(out_valid), 32'd0);
        check("nobypass_out_pc",    out_pc,         32'd0);
        step();
        drive(1'b0, 32'd0, 32'd0);
        check("nobypass_count", 32'(count), 32'd1);
        check("nobypass_pc",    out_pc,     32'd44);
        step();
`endif
        check("final_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
